// File: rtl/pair_word_receiver_if.sv
// Handshake bundle for pair_word_receiver: burst control, complemented-pair
// input stream, FIFO output stream and burst status.
interface pair_word_receiver_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic [N-1:0] in_inv;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   err_count;
  logic         overflow;

  modport master (
    output start, in_valid, in_data, in_inv, out_ready,
    input  out_data, out_valid, busy, done, err, err_count, overflow
  );

  modport slave (
    input  start, in_valid, in_data, in_inv, out_ready,
    output out_data, out_valid, busy, done, err, err_count, overflow
  );
endinterface

// File: rtl/pair_word_receiver.sv
// Receives BURST data/complement pairs, discards corrupted words, buffers good
// words in a first-word-fall-through FIFO and reports burst status.
module pair_word_receiver #(
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  pair_word_receiver_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] FILL_FULL = DEPTH[AW:0];
  localparam logic [AW:0] FILL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]  LAST_IDX  = 8'(BURST - 1);

  logic [1:0]   r_state;
  logic [7:0]   r_word_cnt;
  logic         r_err;
  logic [7:0]   r_err_count;
  logic         r_overflow;

  logic [N-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  logic [AW:0]  w_fill;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_accept;
  logic         w_good;
  logic         w_push;
  logic         w_drop;
  logic         w_bad;
  logic         w_drained;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_fill    = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_fill == '0);
  assign w_full    = (w_fill == FILL_FULL);
  assign w_pop     = !w_empty && bus.out_ready;

  assign w_accept  = (r_state == S_RECV) && bus.in_valid;
  assign w_good    = (bus.in_data == ~bus.in_inv);
  assign w_bad     = w_accept && !w_good;
  assign w_push    = w_accept && w_good && (!w_full || w_pop);
  assign w_drop    = w_accept && w_good && w_full && !w_pop;
  // Popping the last remaining word on this edge already counts as empty.
  assign w_drained = w_empty || ((w_fill == FILL_ONE) && w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_RECV;
            r_word_cnt  <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_overflow  <= 1'b0;
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + 8'd1;
            if (r_word_cnt == LAST_IDX) begin
              r_state <= S_DRAIN;
            end
          end
          if (w_bad) begin
            r_err <= 1'b1;
            if (r_err_count != '1) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FILL_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.out_valid = !w_empty;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_pair_word_receiver.sv
// Bench for pair_word_receiver: directed burst scenarios plus random bursts
// compared cycle by cycle against a queue-based behavioural model.
module tb_pair_word_receiver;
  localparam int unsigned N     = 4;
  localparam int unsigned BURST = 10;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pair_word_receiver_if #(.N(N)) bus ();

  pair_word_receiver #(.N(N), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the burst receiver.
  logic [N-1:0] q[$];
  bit           m_recv, m_drain, m_done, m_err, m_ovf;
  int           m_left, m_ec;
  // Observations collected while driving.
  logic [N-1:0] popped[$];
  int           dones;

  task automatic model_reset();
    q.delete();
    m_recv = 0; m_drain = 0; m_done = 0; m_err = 0; m_ovf = 0;
    m_left = 0; m_ec = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit pop, acc, good;
    sz   = q.size();
    pop  = (sz > 0) && bus.out_ready;
    acc  = m_recv && bus.in_valid;
    good = (bus.in_data == ~bus.in_inv);
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (good) begin
        if (sz < DEPTH || pop) q.push_back(bus.in_data);
        else m_ovf = 1;
      end else begin
        m_err = 1;
        if (m_ec < 255) m_ec++;
      end
    end
    if (m_done) m_done = 0;
    else if (m_drain) begin
      if (sz == 0 || (sz == 1 && pop)) begin m_drain = 0; m_done = 1; end
    end else if (m_recv) begin
      if (acc) begin
        m_left--;
        if (m_left == 0) begin m_recv = 0; m_drain = 1; end
      end
    end else if (bus.start) begin
      m_recv = 1; m_left = BURST; m_err = 0; m_ec = 0; m_ovf = 0;
    end
  endtask

  task automatic cyc(input bit s, input bit v, input logic [N-1:0] d,
                     input logic [N-1:0] inv, input bit rdy);
    bus.start = s; bus.in_valid = v; bus.in_data = d; bus.in_inv = inv;
    bus.out_ready = rdy;
    if (bus.out_valid === 1'b1 && rdy) popped.push_back(bus.out_data);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    if (bus.done === 1'b1) dones++;
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget && bus.busy !== 1'b0; k++) cyc(0, 0, '0, '0, 1);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL drain_timeout: busy=%b after %0d cycles, need 0", bus.busy, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1, 1, 4'h3, 4'hC, 1);
    cyc(1, 1, 4'h5, 4'hA, 1);
    checks++;
    if ({bus.out_valid, bus.busy, bus.done, bus.err, bus.overflow} !== 5'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b err=%b ovf=%b ec=%0d, need all 0",
               bus.out_valid, bus.busy, bus.done, bus.err, bus.overflow, bus.err_count);
    end
    rst = 1'b0;
    cyc(0, 0, '0, '0, 0);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy=%b need 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [N-1:0] d;
    popped.delete(); dones = 0;
    cyc(1, 0, '0, '0, 1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b need 1", bus.busy); end
    for (int i = 0; i < 10; i++) begin d = 4'(i); cyc(0, 1, d, ~d, 1); end
    drain(20);
    checks++;
    if (popped.size() != 10) begin errors++; $display("FAIL basic_count: got %0d words need 10", popped.size()); end
    for (int i = 0; i < popped.size() && i < 10; i++) begin
      checks++;
      if (popped[i] !== 4'(i)) begin errors++; $display("FAIL basic_order[%0d]: got %0d need %0d", i, popped[i], i); end
    end
    checks++;
    if (bus.err !== 1'b0 || bus.err_count !== 8'd0 || dones != 1) begin
      errors++; $display("FAIL basic_status: err=%b ec=%0d dones=%0d, need 0 0 1", bus.err, bus.err_count, dones);
    end
  endtask

  task automatic test_bad_words();
    logic [N-1:0] d;
    popped.delete(); dones = 0;
    cyc(1, 0, '0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      d = 4'(i);
      cyc(0, 1, d, (i == 3 || i == 7) ? d : ~d, 1);
    end
    drain(20);
    checks++;
    if (popped.size() != 8) begin errors++; $display("FAIL bad_count: got %0d words need 8", popped.size()); end
    checks++;
    if (bus.err !== 1'b1 || bus.err_count !== 8'd2 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL bad_status: err=%b ec=%0d ovf=%b, need 1 2 0", bus.err, bus.err_count, bus.overflow);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] d;
    popped.delete(); dones = 0;
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 10; i++) begin d = 4'(i); cyc(0, 1, d, ~d, 0); end
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0);
    checks++;
    if (bus.busy !== 1'b1 || bus.overflow !== 1'b1 || bus.out_valid !== 1'b1 || dones != 0) begin
      errors++; $display("FAIL ovf_hold: busy=%b ovf=%b valid=%b dones=%0d, need 1 1 1 0",
                         bus.busy, bus.overflow, bus.out_valid, dones);
    end
    drain(20);
    checks++;
    if (popped.size() != 4 || dones != 1) begin
      errors++; $display("FAIL ovf_drain: got %0d words %0d dones, need 4 1", popped.size(), dones);
    end
    for (int i = 0; i < popped.size() && i < 4; i++) begin
      checks++;
      if (popped[i] !== 4'(i)) begin errors++; $display("FAIL ovf_order[%0d]: got %0d need %0d", i, popped[i], i); end
    end
  endtask

  task automatic test_full_pop();
    logic [N-1:0] d;
    popped.delete(); dones = 0;
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) begin d = 4'(i); cyc(0, 1, d, ~d, 0); end
    d = 4'd4; cyc(0, 1, d, ~d, 1);
    for (int i = 5; i < 10; i++) begin d = 4'(i); cyc(0, 1, d, d, 0); end
    checks++;
    if (bus.overflow !== 1'b0 || bus.err_count !== 8'd5) begin
      errors++; $display("FAIL fullpop_status: ovf=%b ec=%0d, need 0 5", bus.overflow, bus.err_count);
    end
    drain(20);
    checks++;
    if (popped.size() != 5) begin errors++; $display("FAIL fullpop_count: got %0d words need 5", popped.size()); end
    for (int i = 0; i < popped.size() && i < 5; i++) begin
      checks++;
      if (popped[i] !== 4'(i)) begin errors++; $display("FAIL fullpop_order[%0d]: got %0d need %0d", i, popped[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    logic [N-1:0] sent[$];
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) begin d = 4'(i); cyc(0, 1, d, d, 0); end
    for (int i = 3; i < 5; i++) begin d = 4'(i); cyc(0, 1, d, ~d, 0); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL mid_prefill: valid=%b busy=%b, need 1 1", bus.out_valid, bus.busy);
    end
    rst = 1'b1; model_reset(); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_async: valid=%b busy=%b, need 0 0", bus.out_valid, bus.busy);
    end
    cyc(1, 0, '0, '0, 1);
    cyc(1, 0, '0, '0, 1);
    rst = 1'b0;
    cyc(0, 0, '0, '0, 1);
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_idle: busy=%b valid=%b, need 0 0", bus.busy, bus.out_valid);
    end
    popped.delete(); dones = 0;
    cyc(1, 0, '0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      d = 4'($urandom_range(0, 15)); sent.push_back(d); cyc(0, 1, d, ~d, 1);
    end
    drain(20);
    checks++;
    if (popped.size() != 10 || dones != 1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL mid_reburst: words=%0d dones=%0d err=%b, need 10 1 0", popped.size(), dones, bus.err);
    end
    for (int i = 0; i < popped.size() && i < 10; i++) begin
      checks++;
      if (popped[i] !== sent[i]) begin errors++; $display("FAIL mid_data[%0d]: got %0d need %0d", i, popped[i], sent[i]); end
    end
  endtask

  task automatic test_ignored();
    logic [N-1:0] d;
    popped.delete(); dones = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'h5, 4'hA, 1);
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL ign_idle: busy=%b valid=%b, need 0 0", bus.busy, bus.out_valid);
    end
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 10; i++) begin d = 4'(i + 6); cyc(1, 1, d, ~d, 0); end
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 4'h1, 4'hE, 0); cyc(0, 1, 4'h2, 4'h2, 0); end
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.err_count !== 8'd0 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL ign_drain: busy=%b valid=%b ec=%0d ovf=%b, need 1 1 0 1",
                         bus.busy, bus.out_valid, bus.err_count, bus.overflow);
    end
    drain(20);
    checks++;
    if (popped.size() != 4 || dones != 1) begin
      errors++; $display("FAIL ign_words: got %0d words %0d dones, need 4 1", popped.size(), dones);
    end
    for (int i = 0; i < popped.size() && i < 4; i++) begin
      checks++;
      if (popped[i] !== 4'(i + 6)) begin errors++; $display("FAIL ign_order[%0d]: got %0d need %0d", i, popped[i], i + 6); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d, inv, msk;
    bit v, rdy, s;
    int n;
    for (int b = 0; b < 6; b++) begin
      n = 0;
      cyc(1, 0, '0, '0, $urandom_range(0, 1));
      while ((m_recv || m_drain || m_done) && n < 300) begin
        d   = 4'($urandom_range(0, 15));
        msk = 4'(1 << $urandom_range(0, 3));
        inv = ($urandom_range(0, 4) == 0) ? (~d ^ msk) : ~d;
        v   = ($urandom_range(0, 9) < 7);
        rdy = ($urandom_range(0, 1) == 1);
        s   = ($urandom_range(0, 7) == 0);
        cyc(s, v, d, inv, rdy);
        n++;
        checks++;
        if (bus.out_valid !== (q.size() != 0) || bus.busy !== (m_recv || m_drain || m_done) ||
            bus.done !== m_done) begin
          errors++; $display("FAIL rand_ctrl b%0d c%0d: valid=%b busy=%b done=%b, need %b %b %b", b, n,
                             bus.out_valid, bus.busy, bus.done, q.size() != 0, m_recv || m_drain || m_done, m_done);
        end
        checks++;
        if (bus.err !== m_err || bus.err_count !== 8'(m_ec) || bus.overflow !== m_ovf) begin
          errors++; $display("FAIL rand_status b%0d c%0d: err=%b ec=%0d ovf=%b, need %b %0d %b", b, n,
                             bus.err, bus.err_count, bus.overflow, m_err, m_ec, m_ovf);
        end
        if (q.size() != 0) begin
          checks++;
          if (bus.out_data !== q[0]) begin
            errors++; $display("FAIL rand_data b%0d c%0d: got %0d need %0d", b, n, bus.out_data, q[0]);
          end
        end
      end
      checks++;
      if (m_recv || m_drain || m_done) begin
        errors++; $display("FAIL rand_timeout b%0d: burst still active after %0d cycles", b, n);
      end
    end
  endtask

  initial begin
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.in_inv = '0; bus.out_ready = 0;
    model_reset();
    test_reset();
    test_basic();
    test_bad_words();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
